// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: load/run sequencer for a small processor.
// Loads load_len words into instruction memory, then releases the processor
// from reset and counts its cycles. A run stops on abort, on ebreak (when
// RUN_CTRL_EBREAK_EN is defined) or when the optional cycle limit is reached.
//
// Optional feature macro: RUN_CTRL_EBREAK_EN enables ebreak detection on cpu_instr.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         sequence control (start in IDLE/HALT, abort in LOAD/RUN)
//   load_len             words to load, sampled on an accepted start
//   cycle_limit          max run cycles (0 = unlimited), sampled on an accepted start
//   load_valid/load_data load word stream, load_ready = accepting
//   imem_we/addr/wdata   instruction-memory write port (same-cycle as the transfer)
//   cpu_rst              processor reset, low only in RUN
//   cpu_instr            instruction currently executing in the processor
//   busy, done           LOAD/RUN and HALT indicators
//   halt_cause           0 none, 1 ebreak, 2 cycle limit, 3 abort
//   cycle_count          cycles of the current or last run
module cpu_run_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   load_len,
  input  logic [CNT_W-1:0]  cycle_limit,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  input  logic [31:0]       cpu_instr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT  = 2'd2;
  localparam logic [1:0] CAUSE_ABORT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [1:0]        halt_cause_q, halt_cause_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              load_ready_q, load_ready_d;

  logic              xfer_c;
  logic              ebreak_c;
  logic [LEN_W-1:0]  wcnt_inc_c;
  logic [CNT_W:0]    cnt_inc_c;

  // Ebreak detection, compiled out entirely when the feature is disabled
`ifdef RUN_CTRL_EBREAK_EN
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  assign ebreak_c = (cpu_instr == EBREAK_INSTR);
`else
  logic unused_cpu_instr;
  assign unused_cpu_instr = ^cpu_instr;
  assign ebreak_c         = 1'b0;
`endif

  // Memory write port is combinational so a word lands in its transfer cycle
  assign xfer_c     = (state_q == ST_LOAD) && load_valid;
  assign imem_we    = xfer_c;
  assign imem_addr  = wcnt_q[ADDR_W-1:0];
  assign imem_wdata = load_data;

  assign load_ready  = load_ready_q;
  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halt_cause  = halt_cause_q;
  assign cycle_count = cycle_count_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    len_d         = len_q;
    limit_d       = limit_q;
    cycle_count_d = cycle_count_q;
    halt_cause_d  = halt_cause_q;
    wcnt_inc_c    = wcnt_q + LEN_W'(1);
    // One extra bit so the all-ones count is detectable for saturation
    cnt_inc_c     = {1'b0, cycle_count_q} + (CNT_W+1)'(1);

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          len_d         = load_len;
          limit_d       = cycle_limit;
          wcnt_d        = '0;
          cycle_count_d = '0;
          halt_cause_d  = CAUSE_NONE;
          state_d       = (load_len == '0) ? ST_RUN : ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Word index may exceed the memory depth; the address wraps via truncation
        if (xfer_c) wcnt_d = wcnt_inc_c;
        if (abort) begin
          state_d      = ST_HALT;
          halt_cause_d = CAUSE_ABORT;
        end else if (xfer_c && (wcnt_inc_c == len_q)) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Abort and ebreak cycles are not counted; limit cycle is
        if (abort) begin
          state_d      = ST_HALT;
          halt_cause_d = CAUSE_ABORT;
        end else if (ebreak_c) begin
          state_d      = ST_HALT;
          halt_cause_d = CAUSE_EBREAK;
        end else begin
          cycle_count_d = cnt_inc_c[CNT_W] ? cycle_count_q : cnt_inc_c[CNT_W-1:0];
          if ((limit_q != '0) && (cnt_inc_c == {1'b0, limit_q})) begin
            state_d      = ST_HALT;
            halt_cause_d = CAUSE_LIMIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Status outputs registered from the next state so they track state_q exactly
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d       = (state_d == ST_HALT);
    cpu_rst_d    = (state_d != ST_RUN);
    load_ready_d = (state_d == ST_LOAD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wcnt_q        <= '0;
      len_q         <= '0;
      limit_q       <= '0;
      cycle_count_q <= '0;
      halt_cause_q  <= CAUSE_NONE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cpu_rst_q     <= 1'b1;
      load_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      len_q         <= len_d;
      limit_q       <= limit_d;
      cycle_count_q <= cycle_count_d;
      halt_cause_q  <= halt_cause_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cpu_rst_q     <= cpu_rst_d;
      load_ready_q  <= load_ready_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed scenarios followed by random stimulus,
// checked cycle by cycle against a behavioural model of the load/run sequence.
module tb_cpu_run_ctrl;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CNT_W  = 16;
  localparam int DEPTH = 64;
  localparam int CNT_MAX = 65535;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

`ifdef RUN_CTRL_EBREAK_EN
  localparam bit EB_EN = 1'b1;
`else
  localparam bit EB_EN = 1'b0;
`endif

  // Model phases
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_HALT = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   load_len;
  logic [CNT_W-1:0]  cycle_limit;
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic [31:0]       cpu_instr;
  logic              busy;
  logic              done;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_count;

  cpu_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .load_len(load_len), .cycle_limit(cycle_limit),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .cpu_instr(cpu_instr), .busy(busy), .done(done),
    .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_phase, m_idx, m_len, m_limit, m_cnt, m_cause;
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] dut_mem [DEPTH];
  int dut_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_idx = 0; m_len = 0; m_limit = 0; m_cnt = 0; m_cause = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    case (m_phase)
      P_IDLE, P_HALT: begin
        if (start) begin
          m_len = int'(load_len); m_limit = int'(cycle_limit);
          m_idx = 0; m_cnt = 0; m_cause = 0;
          m_phase = (m_len == 0) ? P_RUN : P_LOAD;
        end
      end
      P_LOAD: begin
        if (load_valid) begin
          exp_mem[m_idx % DEPTH] = load_data;
          m_idx++;
        end
        if (abort) begin
          m_phase = P_HALT; m_cause = 3;
        end else if (load_valid && m_idx == m_len) begin
          m_phase = P_RUN;
        end
      end
      default: begin
        if (abort) begin
          m_phase = P_HALT; m_cause = 3;
        end else if (EB_EN && cpu_instr == EBREAK) begin
          m_phase = P_HALT; m_cause = 1;
        end else begin
          if (m_limit != 0 && m_cnt + 1 == m_limit) begin
            m_phase = P_HALT; m_cause = 2;
          end
          m_cnt = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
        end
      end
    endcase
  endtask

  task automatic check_regs();
    chk("busy",        32'(busy),        32'(m_phase == P_LOAD || m_phase == P_RUN));
    chk("done",        32'(done),        32'(m_phase == P_HALT));
    chk("cpu_rst",     32'(cpu_rst),     32'(m_phase != P_RUN));
    chk("load_ready",  32'(load_ready),  32'(m_phase == P_LOAD));
    chk("halt_cause",  32'(halt_cause),  32'(m_cause));
    chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
    chk("imem_addr",   32'(imem_addr),   32'(m_idx % DEPTH));
  endtask

  // One clock: called just after a falling edge with inputs applied
  task automatic cyc();
    bit exp_we;
    #1;
    exp_we = (m_phase == P_LOAD) && load_valid;
    chk("imem_we", 32'(imem_we), 32'(exp_we));
    if (exp_we) chk("imem_wdata", imem_wdata, load_data);
    if (imem_we) begin
      dut_mem[imem_addr] = imem_wdata;
      dut_wr++;
    end
    model_step();
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic set_idle();
    start = 1'b0; abort = 1'b0; load_valid = 1'b0; load_data = '0; cpu_instr = 32'h0000_0013;
  endtask

  task automatic do_start(input int len, input int limit);
    start = 1'b1; load_len = 7'(len); cycle_limit = 16'(limit);
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] words [3];
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = '0; dut_mem[i] = '0;
    end
    dut_wr = 0;
    set_idle();
    load_len = '0; cycle_limit = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_regs();
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b1;            // abort in IDLE is ignored
    cyc();
    abort = 1'b0;
    cyc();

    // Load three words then run
    do_start(3, 0);
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1; load_data = words[k];
      cyc();
    end
    load_valid = 1'b0;
    chk("s1_mem0", dut_mem[0], 32'hA);
    chk("s1_mem1", dut_mem[1], 32'hB);
    chk("s1_mem2", dut_mem[2], 32'hC);
    chk("s1_cpu_rst", 32'(cpu_rst), 32'd0);
    start = 1'b1;            // start in RUN is ignored
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("s1_cause", 32'(halt_cause), 32'd3);

    // Cycle limit of 67 from HALT with no load
    do_start(0, 67);
    n = 0;
    while (m_phase == P_RUN && n < 200) begin
      cyc();
      n++;
    end
    chk("s2_run_cycles", 32'(n), 32'd67);
    chk("s2_count", 32'(cycle_count), 32'd67);
    chk("s2_cause", 32'(halt_cause), 32'd2);
    chk("s2_done", 32'(done), 32'd1);
    repeat (3) cyc();
    chk("s2_hold", 32'(cycle_count), 32'd67);

    // Ebreak after 10 counted cycles
    do_start(0, 0);
    repeat (10) cyc();
    cpu_instr = EBREAK;
    cyc();
    cpu_instr = 32'h0000_0013;
    chk("s3_cause", 32'(halt_cause), EB_EN ? 32'd1 : 32'd0);
    chk("s3_count", 32'(cycle_count), EB_EN ? 32'd10 : 32'd11);
    chk("s3_busy", 32'(busy), EB_EN ? 32'd0 : 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    // Abort and ebreak together
    do_start(0, 0);
    repeat (3) cyc();
    abort = 1'b1; cpu_instr = EBREAK;
    cyc();
    abort = 1'b0; cpu_instr = 32'h0000_0013;
    chk("s4_cause", 32'(halt_cause), 32'd3);
    chk("s4_count", 32'(cycle_count), 32'd3);

    // Abort in LOAD after one of four words
    dut_wr = 0;
    do_start(4, 0);
    load_valid = 1'b1; load_data = 32'h11;
    cyc();
    load_valid = 1'b0;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("s5_writes", 32'(dut_wr), 32'd1);
    chk("s5_mem0", dut_mem[0], 32'h11);
    chk("s5_cause", 32'(halt_cause), 32'd3);

    // Load with 1-3 cycle gaps in load_valid
    dut_wr = 0;
    do_start(5, 0);
    for (int k = 0; k < 5; k++) begin
      load_valid = 1'b0;
      repeat ($urandom_range(1, 3)) cyc();
      load_valid = 1'b1; load_data = $urandom;
      cyc();
    end
    load_valid = 1'b0;
    chk("s6_writes", 32'(dut_wr), 32'd5);
    chk("s6_running", 32'(cpu_rst), 32'd0);

    // Reset pulse mid-RUN
    repeat (4) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Reset during LOAD with a word presented: no write
    do_start(8, 0);
    load_valid = 1'b1; load_data = 32'h55;
    cyc();
    load_data = 32'h66;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s7_no_we", 32'(imem_we), 32'd0);
    check_regs();
    load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Load longer than the memory: address wraps
    dut_wr = 0;
    do_start(66, 0);
    for (int k = 0; k < 66; k++) begin
      load_valid = 1'b1; load_data = 32'h100 + 32'(k);
      cyc();
    end
    load_valid = 1'b0;
    chk("s8_writes", 32'(dut_wr), 32'd66);
    chk("s8_wrap0", dut_mem[0], 32'h140);
    chk("s8_wrap1", dut_mem[1], 32'h141);
    chk("s8_run", 32'(busy), 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      start       = ($urandom_range(0, 9) == 0);
      load_len    = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 8));
      cycle_limit = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 40)) : 16'd0;
      load_valid  = ($urandom_range(0, 9) < 7);
      load_data   = $urandom;
      abort       = ($urandom_range(0, 59) == 0);
      cpu_instr   = ($urandom_range(0, 29) == 0) ? EBREAK : $urandom;
      cyc();
    end
    set_idle();
    cyc();

    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("mem[%0d]", i), dut_mem[i], exp_mem[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
